act_mem_wr_packer: RTL and testbench
====================================

Name: act_mem_wr_packer

Overview:
- Streams 32-bit words from the external write port into the double-buffered activation SRAM of the MAC engine.
- Takes a job (buffer select, byte offset, word count) and generates bank/row addresses.
- Drives a registered write request into the activation memory arbiter and honours its grant.
- Sits directly upstream of the activation memory banks; its sizing derives from the engine's shared parameter package.

Parameters:
- DATA_W, 32, external port / SRAM word width (BIT_WIDTH_EXTERNAL_PORT).
- TOTAL_BYTES, 16384, total activation memory in bytes (TOTAL_ACTIVATION_MEMORY_SIZE).
- BANK_ROWS, 2048, rows per SRAM macro (MACRO_SRAM_N_WORDS_ACT).
- Derived: BYTES_PER_ROW = DATA_W/8 = 4.
- Derived: BUF_ROWS = TOTAL_BYTES/2/BYTES_PER_ROW = 2048.
- Derived: ROW_W = clog2(BANK_ROWS) = 11.
- Derived: OFS_W = clog2(TOTAL_BYTES/2) = 13.
- Derived: LEN_W = ROW_W+1 = 12.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous abort, returns to IDLE
- start_i  in  1  job start pulse
- cfg_buf_i  in  1  target buffer (0/1)
- cfg_ofs_i  in  OFS_W  byte offset within buffer
- cfg_len_i  in  LEN_W  word count, 0..2048
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  input word accepted when valid&ready
- in_data_i  in  DATA_W  input word
- mem_req_o  out  1  write request
- mem_gnt_i  in  1  arbiter grant
- mem_bank_o  out  1  SRAM macro index
- mem_addr_o  out  ROW_W  row within macro
- mem_wdata_o  out  DATA_W  write data
- mem_be_o  out  DATA_W/8  byte enables
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle misaligned-offset pulse

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0.
- FSM states IDLE, RUN, DRAIN.
- IDLE, start_i:
  - cfg_ofs_i[1:0] != 0: err_o=1 and done_o=1 next cycle, stay IDLE, no writes.
  - cfg_len_i == 0: done_o=1 next cycle, stay IDLE.
  - Otherwise latch buf, row = cfg_ofs_i[OFS_W-1:2], remaining = cfg_len_i; go RUN.
- start_i outside IDLE: ignored, no side effects.
- RUN handshake:
  - in_ready_o = (state==RUN) && remaining!=0 && (!mem_req_o || mem_gnt_i).
  - Accepted word registers next cycle onto mem_wdata_o, with mem_req_o=1, mem_bank_o=buf, mem_addr_o=row, mem_be_o=all ones. Latency accept→request is 1 cycle.
  - mem_req_o and the payload hold stable until mem_gnt_i; a request clears the cycle after grant unless a new word is accepted in the granted cycle (full throughput, one word/cycle, with back-to-back grants).
  - On accept: row increments modulo BUF_ROWS (2047→0 wrap, stays in the selected buffer); remaining decrements.
- RUN → DRAIN when the last word is accepted.
- DRAIN: wait for grant of the final request. Then done_o=1 for one cycle, busy_o=0, go IDLE. Grant in the same cycle the last word registers is handled normally.
- busy_o = state != IDLE.
- clear_i (priority over everything except reset): next cycle IDLE, mem_req_o=0, in_ready_o=0. No done_o/err_o. An outstanding ungranted write is dropped.
- Reset mid-job: immediate return to reset values; no partial done.
- Address mapping: buffer b occupies macro b. The bank index equals the buffer select, so writes never cross buffers.

Decomposition:
- Shared package additions:
  - Typedef for the write-request struct (bank, addr, wdata, be).
  - FSM state enum.
  - Derived constants BYTES_PER_ROW, BUF_ROWS, OFS_W, LEN_W, alongside the existing activation memory parameters.
- No sub-module; the single output register stage is inline.

Test Plan:
- Basic job (buf=0, ofs=0x010, len=4), mem_gnt_i tied 1, words A0..A3 one per cycle:
  - Writes at bank0 rows 4,5,6,7 on consecutive cycles.
  - done_o pulses 1 cycle after the row-7 grant.
- Back-pressure (buf=1, ofs=0, len=3), mem_gnt_i low 3 cycles on the 2nd request:
  - in_ready_o stays low while blocked; payload held stable.
  - Bank1 rows 0,1,2 written exactly once each.
- Wrap (buf=1, ofs=0x1FFC, len=3):
  - Writes bank1 rows 2047, 0, 1.
  - Bank0 never requested.
- Misaligned and empty jobs:
  - ofs=0x0006 → err_o and done_o pulse together, mem_req_o never asserted.
  - len=0 → done_o only.
- Abort:
  - clear_i asserted after 2 of 5 words with a pending ungranted request → next cycle mem_req_o=0, busy_o=0, no done_o.
  - A new job then runs cleanly.
- Reset mid-job: rst_ni low during RUN → all outputs 0 asynchronously; start_i ignored while busy.

Source files
------------

// File: rtl/act_mem_wr_packer_pkg.sv
// Shared activation-memory parameters and write-packer types.
// Holds the sizing constants, the write-request payload struct and the
// packer FSM state enum used by act_mem_wr_packer.
package act_mem_wr_packer_pkg;

  // Existing activation memory parameters
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned TOTAL_BYTES = 16384;
  localparam int unsigned BANK_ROWS   = 2048;

  // Derived sizing
  localparam int unsigned BYTES_PER_ROW = DATA_W / 8;
  localparam int unsigned BE_W          = BYTES_PER_ROW;
  localparam int unsigned BUF_ROWS      = TOTAL_BYTES / 2 / BYTES_PER_ROW;
  localparam int unsigned ROW_W         = $clog2(BANK_ROWS);
  localparam int unsigned OFS_W         = $clog2(TOTAL_BYTES / 2);
  localparam int unsigned LEN_W         = ROW_W + 1;

  // Payload of one write into the activation SRAM
  typedef struct packed {
    logic              bank;
    logic [ROW_W-1:0]  addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } wr_req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/act_mem_wr_packer.sv
// Activation memory write packer.
// Streams 32-bit words from the external write port into one half of the
// double-buffered activation SRAM. A job (buffer, byte offset, word count)
// is latched on start_i; each accepted word becomes a registered write
// request that is held until the arbiter grants it.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   clear_i               synchronous abort back to idle
//   start_i, cfg_*        job start pulse and job configuration
//   in_valid_i/in_ready_o input word handshake, in_data_i word
//   mem_req_o/mem_gnt_i   write request to arbiter and its grant
//   mem_bank_o/addr/wdata/be  registered write payload
//   busy_o                job in progress
//   done_o, err_o         one-cycle completion / misaligned-offset pulses
module act_mem_wr_packer
  import act_mem_wr_packer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic              cfg_buf_i,
  input  logic [OFS_W-1:0]  cfg_ofs_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_bank_o,
  output logic [ROW_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [BE_W-1:0]   mem_be_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  state_e           r_state, w_state_nxt;
  logic             r_buf,   w_buf_nxt;
  logic [ROW_W-1:0] r_row,   w_row_nxt;
  logic [LEN_W-1:0] r_rem,   w_rem_nxt;
  logic             r_req,   w_req_nxt;
  wr_req_t          r_wr,    w_wr_nxt;
  logic             r_done,  w_done_nxt;
  logic             r_err,   w_err_nxt;

  logic w_ready;
  logic w_accept;
  logic w_granted;

  // A new word may enter when the output slot is empty or drains this cycle
  assign w_ready   = (r_state == ST_RUN) && (r_rem != '0) && (!r_req || mem_gnt_i);
  assign w_accept  = w_ready && in_valid_i;
  assign w_granted = r_req && mem_gnt_i;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_row_nxt   = r_row;
    w_rem_nxt   = r_rem;
    w_req_nxt   = r_req;
    w_wr_nxt    = r_wr;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    if (w_granted) begin
      w_req_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (cfg_ofs_i[1:0] != 2'b00) begin
            w_err_nxt  = 1'b1;
            w_done_nxt = 1'b1;
          end else if (cfg_len_i == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_buf_nxt   = cfg_buf_i;
            w_row_nxt   = ROW_W'(cfg_ofs_i[OFS_W-1:2]);
            w_rem_nxt   = cfg_len_i;
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          w_req_nxt      = 1'b1;
          w_wr_nxt.bank  = r_buf;
          w_wr_nxt.addr  = r_row;
          w_wr_nxt.wdata = in_data_i;
          w_wr_nxt.be    = '1;
          // Row wraps inside the selected buffer
          w_row_nxt = (r_row == ROW_W'(BUF_ROWS - 1)) ? '0 : r_row + ROW_W'(1);
          w_rem_nxt = r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1)) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_granted) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Abort drops any ungranted write and suppresses completion pulses
    if (clear_i) begin
      w_state_nxt = ST_IDLE;
      w_req_nxt   = 1'b0;
      w_rem_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_buf   <= 1'b0;
      r_row   <= '0;
      r_rem   <= '0;
      r_req   <= 1'b0;
      r_wr    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_row   <= w_row_nxt;
      r_rem   <= w_rem_nxt;
      r_req   <= w_req_nxt;
      r_wr    <= w_wr_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign in_ready_o  = w_ready;
  assign mem_req_o   = r_req;
  assign mem_bank_o  = r_wr.bank;
  assign mem_addr_o  = r_wr.addr;
  assign mem_wdata_o = r_wr.wdata;
  assign mem_be_o    = r_wr.be;
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_act_mem_wr_packer.sv
// Bench for act_mem_wr_packer: randomized jobs checked against a
// queue-based model of the expected SRAM writes (bank, row, data).
module tb_act_mem_wr_packer;
  import act_mem_wr_packer_pkg::*;

  localparam int unsigned WR_W = 1 + ROW_W + DATA_W;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              clear_i;
  logic              start_i;
  logic              cfg_buf_i;
  logic [OFS_W-1:0]  cfg_ofs_i;
  logic [LEN_W-1:0]  cfg_len_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              mem_req_o;
  logic              mem_gnt_i;
  logic              mem_bank_o;
  logic [ROW_W-1:0]  mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [BE_W-1:0]   mem_be_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  act_mem_wr_packer dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .cfg_buf_i   (cfg_buf_i),
    .cfg_ofs_i   (cfg_ofs_i),
    .cfg_len_i   (cfg_len_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .mem_req_o   (mem_req_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_bank_o  (mem_bank_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Observed traffic, collected on the falling edge
  logic [WR_W-1:0] act_q[$];
  int              gnt_cyc_q[$];
  int              cyc = 0;
  int              done_cnt = 0, err_cnt = 0, last_done_cyc = 0;
  int              bank0_req = 0, req_seen = 0;
  int              hold_viol = 0, rdy_viol = 0, be_viol = 0, errdone_viol = 0;
  logic            prev_hold = 1'b0;
  logic [WR_W+BE_W-1:0] prev_pl = '0;

  always @(negedge clk_i) begin
    cyc <= cyc + 1;
    if (!rst_ni) begin
      prev_hold <= 1'b0;
    end else begin
      if (mem_req_o && mem_gnt_i) begin
        act_q.push_back({mem_bank_o, mem_addr_o, mem_wdata_o});
        gnt_cyc_q.push_back(cyc);
        if (mem_be_o !== {BE_W{1'b1}}) be_viol <= be_viol + 1;
      end
      if (mem_req_o) req_seen <= req_seen + 1;
      if (mem_req_o && !mem_bank_o) bank0_req <= bank0_req + 1;
      if (done_o) begin
        done_cnt      <= done_cnt + 1;
        last_done_cyc <= cyc;
      end
      if (err_o) begin
        err_cnt <= err_cnt + 1;
        if (!done_o) errdone_viol <= errdone_viol + 1;
      end
      if (prev_hold && !(mem_req_o && {mem_bank_o, mem_addr_o, mem_wdata_o, mem_be_o} == prev_pl))
        hold_viol <= hold_viol + 1;
      if (mem_req_o && !mem_gnt_i && in_ready_o) rdy_viol <= rdy_viol + 1;
      prev_hold <= mem_req_o && !mem_gnt_i && !clear_i;
      prev_pl   <= {mem_bank_o, mem_addr_o, mem_wdata_o, mem_be_o};
    end
  end

  // One job: build the expected write list, drive it, compare
  task automatic run_job(input logic b, input int ofs, input int len, input int valid_pct,
                         input int gnt_pct, input int stall_idx, input int stall_len,
                         input bit poke, input string name);
    logic [DATA_W-1:0] words[$];
    logic [WR_W-1:0]   exp_q[$];
    int base, d0, e0, idx, n, budget, stall_left, got;
    bit exp_err, exp_wr;
    exp_err = (ofs % 4) != 0;
    exp_wr  = !exp_err && (len != 0);
    for (int i = 0; i < len; i++) begin
      words.push_back($urandom);
      if (exp_wr) exp_q.push_back({b, ROW_W'(((ofs / 4) + i) % int'(BUF_ROWS)), words[i]});
    end
    base = act_q.size(); d0 = done_cnt; e0 = err_cnt;
    stall_left = stall_len; budget = 20 * len + 50;
    @(posedge clk_i); #1;
    start_i = 1'b1; cfg_buf_i = b; cfg_ofs_i = OFS_W'(ofs); cfg_len_i = LEN_W'(len);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    idx = 0; n = 0;
    while (done_cnt == d0 && n < budget) begin
      in_valid_i = (idx < len) && exp_wr && (int'($urandom_range(99)) < valid_pct);
      if (idx < len) in_data_i = words[idx];
      mem_gnt_i = int'($urandom_range(99)) < gnt_pct;
      if (mem_req_o && (act_q.size() - base) == stall_idx && stall_left > 0) begin
        mem_gnt_i = 1'b0;
        stall_left--;
      end
      start_i = 1'b0;
      if (poke && n == 3 && busy_o) begin
        start_i = 1'b1; cfg_buf_i = ~b; cfg_ofs_i = OFS_W'(4); cfg_len_i = LEN_W'(1);
      end
      @(negedge clk_i);
      if (in_valid_i && in_ready_o) idx++;
      @(posedge clk_i); #1;
      n++;
    end
    in_valid_i = 1'b0; mem_gnt_i = 1'b0; start_i = 1'b0;
    @(posedge clk_i); #1;
    total++;
    if (n >= budget) begin
      bad++; $display("FAIL %s timeout: cycles=%0d limit=%0d", name, n, budget);
    end
    got = act_q.size() - base;
    total++;
    if (got != exp_q.size()) begin
      bad++; $display("FAIL %s write_count: got=%0d exp=%0d", name, got, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got; i++) begin
      total++;
      if (act_q[base + i] !== exp_q[i]) begin
        bad++; $display("FAIL %s write[%0d]: got=%h exp=%h", name, i, act_q[base + i], exp_q[i]);
      end
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL %s done_pulses: got=%0d exp=1", name, done_cnt - d0);
    end
    total++;
    if (err_cnt - e0 != int'(exp_err)) begin
      bad++; $display("FAIL %s err_pulses: got=%0d exp=%0d", name, err_cnt - e0, int'(exp_err));
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #3;
    total++;
    if ({mem_req_o, in_ready_o, busy_o, done_o, err_o, mem_bank_o} !== 6'b0 ||
        mem_addr_o !== '0 || mem_wdata_o !== '0 || mem_be_o !== '0) begin
      bad++; $display("FAIL reset_outputs: req=%b rdy=%b busy=%b done=%b err=%b exp all 0",
                      mem_req_o, in_ready_o, busy_o, done_o, err_o);
    end
    start_i = 1'b1; cfg_len_i = LEN_W'(4);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("FAIL reset_hold: busy=%b done=%b exp 0 0", busy_o, done_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    int sz;
    run_job(1'b0, 'h010, 4, 100, 100, -1, 0, 1'b0, "basic");
    sz = gnt_cyc_q.size();
    total++;
    if (sz < 4) begin
      bad++; $display("FAIL basic_grants: got=%0d exp>=4", sz);
    end else begin
      for (int k = 1; k < 4; k++) begin
        total++;
        if (gnt_cyc_q[sz - 4 + k] - gnt_cyc_q[sz - 5 + k] != 1) begin
          bad++; $display("FAIL basic_consecutive[%0d]: gap=%0d exp=1", k,
                          gnt_cyc_q[sz - 4 + k] - gnt_cyc_q[sz - 5 + k]);
        end
      end
      total++;
      if (last_done_cyc != gnt_cyc_q[sz - 1] + 1) begin
        bad++; $display("FAIL basic_done_latency: got=%0d exp=%0d", last_done_cyc, gnt_cyc_q[sz - 1] + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int h0, r0, sz;
    h0 = hold_viol; r0 = rdy_viol;
    run_job(1'b1, 'h000, 3, 100, 100, 1, 3, 1'b0, "backpressure");
    sz = gnt_cyc_q.size();
    total++;
    if (sz < 3 || gnt_cyc_q[sz - 2] - gnt_cyc_q[sz - 3] != 4) begin
      bad++; $display("FAIL bp_stall_gap: got=%0d exp=4", (sz < 3) ? -1 : gnt_cyc_q[sz - 2] - gnt_cyc_q[sz - 3]);
    end
    total++;
    if (hold_viol != h0) begin
      bad++; $display("FAIL bp_payload_hold: violations=%0d exp=0", hold_viol - h0);
    end
    total++;
    if (rdy_viol != r0) begin
      bad++; $display("FAIL bp_ready_blocked: violations=%0d exp=0", rdy_viol - r0);
    end
  endtask

  task automatic test_wrap();
    int b0;
    b0 = bank0_req;
    run_job(1'b1, 'h1FFC, 3, 80, 70, -1, 0, 1'b0, "wrap");
    total++;
    if (bank0_req != b0) begin
      bad++; $display("FAIL wrap_bank0: requests=%0d exp=0", bank0_req - b0);
    end
  endtask

  task automatic test_misaligned_empty();
    int q0;
    q0 = req_seen;
    run_job(1'b0, 'h0006, 3, 100, 100, -1, 0, 1'b0, "misaligned");
    run_job(1'b1, 'h0008, 0, 100, 100, -1, 0, 1'b0, "empty");
    total++;
    if (req_seen != q0) begin
      bad++; $display("FAIL noop_requests: got=%0d exp=0", req_seen - q0);
    end
    total++;
    if (errdone_viol != 0) begin
      bad++; $display("FAIL err_without_done: got=%0d exp=0", errdone_viol);
    end
  endtask

  task automatic test_abort();
    logic [DATA_W-1:0] w0, w1;
    int base, d0, idx, n;
    base = act_q.size(); d0 = done_cnt;
    w0 = $urandom; w1 = $urandom;
    @(posedge clk_i); #1;
    start_i = 1'b1; cfg_buf_i = 1'b0; cfg_ofs_i = OFS_W'('h20); cfg_len_i = LEN_W'(5);
    @(posedge clk_i); #1;
    start_i = 1'b0; in_valid_i = 1'b1; mem_gnt_i = 1'b1;
    idx = 0; n = 0;
    while (idx < 2 && n < 20) begin
      in_data_i = (idx == 0) ? w0 : w1;
      @(negedge clk_i);
      if (in_ready_o) idx++;
      @(posedge clk_i); #1;
      n++;
    end
    in_valid_i = 1'b0; mem_gnt_i = 1'b0;
    total++;
    if (mem_req_o !== 1'b1 || idx != 2) begin
      bad++; $display("FAIL abort_pending: req=%b accepted=%0d exp 1 2", mem_req_o, idx);
    end
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0; mem_gnt_i = 1'b1; in_valid_i = 1'b1;
    #1;
    total++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
      bad++; $display("FAIL abort_state: req=%b busy=%b rdy=%b exp 0 0 0", mem_req_o, busy_o, in_ready_o);
    end
    repeat (3) @(posedge clk_i);
    #1;
    mem_gnt_i = 1'b0; in_valid_i = 1'b0;
    total++;
    if (done_cnt != d0) begin
      bad++; $display("FAIL abort_done: pulses=%0d exp=0", done_cnt - d0);
    end
    total++;
    if (act_q.size() - base != 1 || act_q[base] !== {1'b0, ROW_W'(8), w0}) begin
      bad++; $display("FAIL abort_writes: count=%0d exp=1 (row 8, first word only)", act_q.size() - base);
    end
    run_job(1'b0, 'h040, 5, 90, 80, -1, 0, 1'b0, "after_abort");
  endtask

  task automatic test_reset_mid_job();
    int d0;
    d0 = done_cnt;
    @(posedge clk_i); #1;
    start_i = 1'b1; cfg_buf_i = 1'b1; cfg_ofs_i = OFS_W'('h40); cfg_len_i = LEN_W'(10);
    @(posedge clk_i); #1;
    start_i = 1'b0; in_valid_i = 1'b1; mem_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data_i = $urandom;
      @(posedge clk_i); #1;
    end
    total++;
    if (busy_o !== 1'b1 || mem_req_o !== 1'b1) begin
      bad++; $display("FAIL midreset_pre: busy=%b req=%b exp 1 1", busy_o, mem_req_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    total++;
    if ({mem_req_o, in_ready_o, busy_o, done_o, err_o, mem_bank_o} !== 6'b0 ||
        mem_addr_o !== '0 || mem_wdata_o !== '0 || mem_be_o !== '0) begin
      bad++; $display("FAIL midreset_outputs: req=%b rdy=%b busy=%b bank=%b addr=%h exp all 0",
                      mem_req_o, in_ready_o, busy_o, mem_bank_o, mem_addr_o);
    end
    in_valid_i = 1'b0; mem_gnt_i = 1'b0;
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    total++;
    if (done_cnt != d0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL midreset_nodone: pulses=%0d busy=%b exp 0 0", done_cnt - d0, busy_o);
    end
    run_job(1'b0, 'h100, 6, 100, 100, -1, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    int len, ofs, vp, gp;
    logic b;
    for (int j = 0; j < 8; j++) begin
      b   = 1'($urandom_range(1));
      len = int'($urandom_range(40));
      if ($urandom_range(5) == 0) ofs = int'($urandom_range(8191));
      else ofs = 4 * int'($urandom_range(2047));
      vp  = int'($urandom_range(100, 60));
      gp  = int'($urandom_range(100, 40));
      run_job(b, ofs, len, vp, gp, -1, 0, 1'b1, "random");
    end
    total++;
    if (hold_viol != 0 || rdy_viol != 0) begin
      bad++; $display("FAIL random_handshake: hold=%0d ready=%0d exp 0 0", hold_viol, rdy_viol);
    end
    total++;
    if (be_viol != 0 || errdone_viol != 0) begin
      bad++; $display("FAIL random_be_err: be=%0d err_alone=%0d exp 0 0", be_viol, errdone_viol);
    end
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; cfg_buf_i = 1'b0;
    cfg_ofs_i = '0; cfg_len_i = '0; in_valid_i = 1'b0; in_data_i = '0; mem_gnt_i = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_misaligned_empty();
    test_abort();
    test_reset_mid_job();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
